// File: rtl/s1_cell_arbiter.sv
// Round-robin arbiter and sequencer that time-shares one S1-type logic cell.
// Each grant runs IDLE -> ISSUE -> CAPTURE -> FLUSH and returns the cell value with a done pulse.
module s1_cell_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] req_lut,
  input  logic [3*N_REQ-1:0] req_sel,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               result,
  output logic               busy,
  output logic [3:0]         cell_d,
  output logic               cell_a0,
  output logic               cell_a1,
  output logic               cell_b1,
  output logic               cell_clr,
  input  logic               cell_out
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_FLUSH   = 2'd3;

  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]       state_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] win_reg;
  logic [IDX_W-1:0] win_next;
  logic             any_req;
  logic [N_REQ-1:0] gnt_reg;
  logic [N_REQ-1:0] done_reg;
  logic             result_reg;
  logic             flush_q_reg;
  logic [3:0]       lut_reg;
  logic [2:0]       sel_reg;

  logic [3:0] lut_arr [N_REQ];
  logic [2:0] sel_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign lut_arr[gi] = req_lut[4*gi +: 4];
      assign sel_arr[gi] = req_sel[3*gi +: 3];
    end
  endgenerate

  // (base + k) mod N_REQ, valid for base < N_REQ and k < N_REQ
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IDX_W-1:0];
  endfunction

  // Scan downward so the lowest offset from rr_ptr wins the last assignment.
  always_comb begin
    win_next = '0;
    any_req  = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[wrap_idx(rr_ptr_reg, k)]) begin
        win_next = wrap_idx(rr_ptr_reg, k);
        any_req  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg   <= ST_IDLE;
      rr_ptr_reg  <= '0;
      win_reg     <= '0;
      gnt_reg     <= '0;
      done_reg    <= '0;
      result_reg  <= 1'b0;
      flush_q_reg <= 1'b0;
      lut_reg     <= '0;
      sel_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            win_reg   <= win_next;
            lut_reg   <= lut_arr[win_next];
            sel_reg   <= sel_arr[win_next];
            gnt_reg   <= ONE_HOT0 << win_next;
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_reg <= ST_CAPTURE;
        ST_CAPTURE: begin
          result_reg  <= cell_out;
          done_reg    <= ONE_HOT0 << win_reg;
          flush_q_reg <= 1'b1;
          state_reg   <= ST_FLUSH;
        end
        ST_FLUSH: begin
          done_reg    <= '0;
          gnt_reg     <= '0;
          flush_q_reg <= 1'b0;
          lut_reg     <= '0;
          sel_reg     <= '0;
          rr_ptr_reg  <= wrap_idx(win_reg, 1);
          state_reg   <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign gnt      = gnt_reg;
  assign done     = done_reg;
  assign result   = result_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign cell_d   = lut_reg;
  assign cell_a0  = sel_reg[0];
  assign cell_a1  = sel_reg[1];
  assign cell_b1  = sel_reg[2];
  assign cell_clr = clr | flush_q_reg;

endmodule

// File: tb/tb_s1_cell_arbiter.sv
// Directed bench for s1_cell_arbiter with a behavioural S1-type cell model attached.
module tb_s1_cell_arbiter;

  localparam int N_REQ = 4;

  logic               clk;
  logic               clr;
  logic [N_REQ-1:0]   req;
  logic [4*N_REQ-1:0] req_lut;
  logic [3*N_REQ-1:0] req_sel;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic               result;
  logic               busy;
  logic [3:0]         cell_d;
  logic               cell_a0;
  logic               cell_a1;
  logic               cell_b1;
  logic               cell_clr;
  logic               cell_out;

  int total;
  int bad;

  s1_cell_arbiter #(.N_REQ(N_REQ)) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .req_lut  (req_lut),
    .req_sel  (req_sel),
    .gnt      (gnt),
    .done     (done),
    .result   (result),
    .busy     (busy),
    .cell_d   (cell_d),
    .cell_a0  (cell_a0),
    .cell_a1  (cell_a1),
    .cell_b1  (cell_b1),
    .cell_clr (cell_clr),
    .cell_out (cell_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // S1 cell: sel1 = A1|B1, sel0 = A0 & CLR, flop with async clear
  logic [1:0] cell_sel;
  logic       cell_mux;
  assign cell_sel = {cell_a1 | cell_b1, cell_a0 & cell_clr};
  assign cell_mux = cell_d[cell_sel];
  always_ff @(posedge clk or posedge cell_clr) begin
    if (cell_clr) cell_out <= 1'b0;
    else          cell_out <= cell_mux;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] lut, input logic [2:0] sel);
    req_lut[4*i +: 4] = lut;
    req_sel[3*i +: 3] = sel;
  endtask

  // Assumes the DUT is in IDLE and the winner's req is already high.
  task automatic do_op(input int w, input logic exp_res, input bit drop);
    logic [3:0] el;
    logic [2:0] es;
    el = req_lut[4*w +: 4];
    es = req_sel[3*w +: 3];
    tick();
    check_val("issue_gnt", 32'(gnt), 32'(1) << w);
    check_val("issue_busy", 32'(busy), 32'd1);
    check_val("issue_cell_d", 32'(cell_d), 32'(el));
    check_val("issue_sel", 32'({cell_b1, cell_a1, cell_a0}), 32'(es));
    check_val("issue_cell_clr", 32'(cell_clr), 32'd0);
    tick();
    check_val("capture_done", 32'(done), 32'd0);
    check_val("capture_gnt", 32'(gnt), 32'(1) << w);
    tick();
    check_val("flush_done", 32'(done), 32'(1) << w);
    check_val("flush_result", 32'(result), 32'(exp_res));
    check_val("flush_cell_clr", 32'(cell_clr), 32'd1);
    if (drop) req[w] = 1'b0;
    tick();
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_gnt", 32'(gnt), 32'd0);
    check_val("idle_done", 32'(done), 32'd0);
    check_val("idle_cell_out", 32'(cell_out), 32'd0);
    check_val("idle_result_held", 32'(result), 32'(exp_res));
    check_val("idle_cell_d", 32'(cell_d), 32'd0);
    $display("op: winner=%0d result=%0b", w, result);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    clr     = 1'b1;
    req     = '0;
    req_lut = '0;
    req_sel = '0;
    tick();
    tick();
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_result", 32'(result), 32'd0);
    check_val("rst_cell_clr", 32'(cell_clr), 32'd1);
    check_val("rst_cell_d", 32'(cell_d), 32'd0);
    check_val("rst_sel", 32'({cell_b1, cell_a1, cell_a0}), 32'd0);
    clr = 1'b0;
    #1;
    check_val("rel_cell_clr", 32'(cell_clr), 32'd0);

    // 1: single request, A1 selects D10
    set_op(0, 4'b0100, 3'b010);
    req = 4'b0001;
    do_op(0, 1'b1, 1'b1);

    // 2: round-robin under full contention, D00 = 1
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_op(i, 4'b0001, 3'b000);
    req = 4'b1111;
    for (int i = 0; i < N_REQ; i++) do_op(i, 1'b1, 1'b0);
    do_op(0, 1'b1, 1'b0);
    req = 4'b0000;

    // 3: pointer wrap and skip of idle requesters
    req = 4'b1000;
    do_op(3, 1'b1, 1'b1);
    req = 4'b0101;
    do_op(0, 1'b1, 1'b1);
    do_op(2, 1'b1, 1'b1);

    // 4: operands latched at grant; B1 selects D10 = 0
    set_op(1, 4'b1011, 3'b100);
    req = 4'b0010;
    tick();
    check_val("t4_gnt", 32'(gnt), 32'b0010);
    req_lut[7:4] = 4'b0000;
    #1;
    check_val("t4_cell_d_latched", 32'(cell_d), 32'b1011);
    check_val("t4_b1", 32'(cell_b1), 32'd1);
    tick();
    check_val("t4_capture_cell_d", 32'(cell_d), 32'b1011);
    tick();
    check_val("t4_done", 32'(done), 32'b0010);
    check_val("t4_result", 32'(result), 32'd0);
    check_val("t4_cell_clr", 32'(cell_clr), 32'd1);
    req = 4'b0000;
    tick();
    check_val("t4_idle_cell_out", 32'(cell_out), 32'd0);
    check_val("t4_idle_busy", 32'(busy), 32'd0);
    $display("op: winner=1 result=%0b (operands changed mid-op)", result);

    // 5: A0 has no effect while cell_clr is low, D00 = 0
    set_op(2, 4'b0010, 3'b001);
    req = 4'b0100;
    do_op(2, 1'b0, 1'b1);

    // 6: clr during CAPTURE; first leave result = 1
    set_op(1, 4'b0001, 3'b000);
    req = 4'b0010;
    do_op(1, 1'b1, 1'b1);
    set_op(0, 4'b0001, 3'b000);
    set_op(3, 4'b0001, 3'b000);
    req = 4'b1001;
    tick();
    check_val("t6_gnt", 32'(gnt), 32'b1000);
    tick();
    #2;
    clr = 1'b1;
    #1;
    check_val("t6_async_gnt", 32'(gnt), 32'd0);
    check_val("t6_async_done", 32'(done), 32'd0);
    check_val("t6_async_busy", 32'(busy), 32'd0);
    check_val("t6_async_result", 32'(result), 32'd0);
    check_val("t6_async_cell_clr", 32'(cell_clr), 32'd1);
    check_val("t6_async_cell_out", 32'(cell_out), 32'd0);
    tick();
    check_val("t6_no_done_a", 32'(done), 32'd0);
    tick();
    check_val("t6_no_done_b", 32'(done), 32'd0);
    clr = 1'b0;
    $display("op: aborted by clr, req=%b held", req);
    do_op(0, 1'b1, 1'b1);
    req = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
